// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding word request at a time, hands the
// word and its PC to decode over valid/ready, and drops stale data on redirect.
module ifu_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH,
        S_HOLD
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;

    logic [DATA_WIDTH-1:0] redirect_tgt;
    logic [DATA_WIDTH-1:0] pc_inc;

    always_comb begin
        redirect_tgt = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
        pc_inc       = pc_q + DATA_WIDTH'(4);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (mem_gnt) begin
                        state_d = S_FLUSH;
                    end
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = mem_rvalid ? S_REQ : S_FLUSH;
                end else if (mem_rvalid) begin
                    state_d    = S_HOLD;
                    instr_d    = mem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_inc;
                end
            end

            S_FLUSH: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                // The stale response retires the outstanding request even when a
                // redirect lands in the same cycle; waiting longer would deadlock.
                if (mem_rvalid) begin
                    state_d = S_REQ;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // A redirect kills the held word in the same cycle, so valid is gated combinationally.
    always_comb begin
        mem_req     = (state_q == S_REQ);
        mem_addr    = pc_q;
        instr_valid = (state_q == S_HOLD) && !redirect_valid;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
    end

endmodule
